// File: rtl/lsu_pkg.sv
// Shared definitions for the multicycle load/store unit: opcodes, funct3
// encodings, FSM states and request-decode helpers.
package lsu_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_e;

   // The low two funct3 bits encode log2 of the access size for every
   // supported load and store.
   function automatic logic [1:0] size_log2(input logic [2:0] funct3);
      return funct3[1:0];
   endfunction

   function automatic logic is_supported(input logic [6:0] opcode,
                                         input logic [2:0] funct3,
                                         input logic       is64);
      logic ok;
      ok = 1'b0;
      if (opcode == OPC_LOAD) begin
         case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            F3_D, F3_WU:                    ok = is64;
            default:                        ok = 1'b0;
         endcase
      end else if (opcode == OPC_STORE) begin
         case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_D:             ok = is64;
            default:          ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic is_aligned(input logic [1:0] size,
                                       input logic [2:0] addr_lo);
      logic ok;
      case (size)
         2'd0:    ok = 1'b1;
         2'd1:    ok = (addr_lo[0] == 1'b0);
         2'd2:    ok = (addr_lo[1:0] == 2'b00);
         default: ok = (addr_lo == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: lane mask and store data shift for outgoing accesses,
// lane extraction plus sign/zero extension for returning load data.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int  XLEN = 32,
   localparam int NB   = XLEN / 8,
   localparam int OFFW = $clog2(NB)
) (
   input  logic [2:0]      funct3,
   input  logic [OFFW-1:0] offset,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [NB-1:0]   mask,
   output logic [XLEN-1:0] wdata_sh,
   output logic [XLEN-1:0] ld_ext
);

   logic [NB-1:0]   size_ones;
   logic [XLEN-1:0] rdata_sh;
   logic [OFFW+2:0] bit_shift;

   assign bit_shift = {offset, 3'b000};

   always_comb begin
      case (size_log2(funct3))
         2'd0:    size_ones = NB'(8'h01);
         2'd1:    size_ones = NB'(8'h03);
         2'd2:    size_ones = NB'(8'h0F);
         default: size_ones = NB'(8'hFF);
      endcase
   end

   assign mask     = size_ones << offset;
   assign wdata_sh = wdata << bit_shift;
   assign rdata_sh = rdata >> bit_shift;

   // Size casts of a $signed operand sign-extend; unsigned operands zero-fill.
   always_comb begin
      case (funct3)
         F3_B:    ld_ext = XLEN'($signed(rdata_sh[7:0]));
         F3_H:    ld_ext = XLEN'($signed(rdata_sh[15:0]));
         F3_W:    ld_ext = XLEN'($signed(rdata_sh[31:0]));
         F3_BU:   ld_ext = XLEN'(rdata_sh[7:0]);
         F3_HU:   ld_ext = XLEN'(rdata_sh[15:0]);
         F3_WU:   ld_ext = XLEN'(rdata_sh[31:0]);
         default: ld_ext = rdata_sh;
      endcase
   end

endmodule

// File: rtl/lsu_multicycle.sv
// Multicycle load/store unit: accepts one aligned access in IDLE, holds it on
// the memory bus in BUSY until mem_valid or timeout, reports in RESP.
module lsu_multicycle
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [6:0]        req_opcode,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              stall,
   output logic [XLEN-1:0]   ld_data,
   output logic              ld_valid,
   output logic              misalign,
   output logic              timeout_err,
   output logic              cs,
   output logic              wr,
   output logic [XLEN/8-1:0] mask,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_valid
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [6:0]        opcode_q, opcode_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [NB-1:0]     mask_q, mask_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   ld_data_q, ld_data_d;
   logic              ld_ok_q, ld_ok_d;
   logic              tmo_q, tmo_d;

   logic              req_ok, req_aligned;
   logic [2:0]        al_funct3;
   logic [OFFW-1:0]   al_offset;
   logic [NB-1:0]     al_mask;
   logic [XLEN-1:0]   al_wdata, al_ld;

   assign req_ok      = is_supported(req_opcode, req_funct3, XLEN == 64);
   assign req_aligned = is_aligned(size_log2(req_funct3), req_addr[2:0]);

   // One aligner serves both directions: request fields while IDLE, the
   // captured access while BUSY.
   assign al_funct3 = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
   assign al_offset = (state_q == ST_IDLE) ? req_addr[OFFW-1:0] : addr_q[OFFW-1:0];

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .funct3   (al_funct3),
      .offset   (al_offset),
      .wdata    (req_wdata),
      .rdata    (mem_rdata),
      .mask     (al_mask),
      .wdata_sh (al_wdata),
      .ld_ext   (al_ld)
   );

   always_comb begin
      // NOTE: every next-state and output gets a default first, so no path through the case can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      opcode_d    = opcode_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      mask_d      = mask_q;
      wdata_d     = wdata_q;
      ld_data_d   = ld_data_q;
      ld_ok_d     = ld_ok_q;
      tmo_d       = tmo_q;
      stall       = 1'b0;
      misalign    = 1'b0;
      cs          = 1'b0;
      wr          = 1'b0;
      mask        = '0;
      mem_addr    = '0;
      mem_wdata   = '0;
      ld_valid    = 1'b0;
      timeout_err = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Gated by rst so the combinational pulses stay low during reset.
            if (rst && req_valid && req_ok) begin
               if (!req_aligned) begin
                  misalign = 1'b1;
               end else begin
                  stall    = 1'b1;
                  state_d  = ST_BUSY;
                  cnt_d    = '0;
                  opcode_d = req_opcode;
                  funct3_d = req_funct3;
                  addr_d   = req_addr;
                  mask_d   = al_mask;
                  wdata_d  = al_wdata;
               end
            end
         end
         ST_BUSY: begin
            stall     = 1'b1;
            cs        = 1'b1;
            wr        = (opcode_q == OPC_STORE);
            mem_addr  = {addr_q[XLEN-1:OFFW], OFFW'(0)};
            mask      = mask_q;
            mem_wdata = wdata_q;
            cnt_d     = cnt_q + 8'd1;
            if (mem_valid) begin
               state_d = ST_RESP;
               tmo_d   = 1'b0;
               ld_ok_d = (opcode_q == OPC_LOAD);
               if (opcode_q == OPC_LOAD) begin
                  ld_data_d = al_ld;
               end
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d = ST_RESP;
               tmo_d   = 1'b1;
               ld_ok_d = 1'b0;
            end
         end
         ST_RESP: begin
            ld_valid    = ld_ok_q;
            timeout_err = tmo_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ld_data = ld_data_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         opcode_q  <= '0;
         funct3_q  <= '0;
         addr_q    <= '0;
         mask_q    <= '0;
         wdata_q   <= '0;
         ld_data_q <= '0;
         ld_ok_q   <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opcode_q  <= opcode_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         mask_q    <= mask_d;
         wdata_q   <= wdata_d;
         ld_data_q <= ld_data_d;
         ld_ok_q   <= ld_ok_d;
         tmo_q     <= tmo_d;
      end
   end

endmodule
